// File: rtl/nibble_serial_adder_pkg.sv
// ============================================================================
//  Module   : nibble_serial_adder_pkg
//  Brief    : Shared types, constants and WIDTH legality check for the
//             nibble-serial adder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic bit width_ok(input int width);
        return ((width % NIBBLE_W) == 0) && (width >= 2 * NIBBLE_W);
    endfunction

endpackage

`default_nettype wire

// File: rtl/cla_nibble.sv
// ============================================================================
//  Module   : cla_nibble
//  Brief    : Combinational 4-bit carry-lookahead adder slice.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_nibble (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [4:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Every carry is a flat sum of products of generate/propagate terms.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum  = w_p ^ w_c[3:0];
    assign cout = w_c[4];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
//  Module   : nibble_serial_adder
//  Brief    : WIDTH-bit adder stepping one nibble per clock through a CLA
//             slice. Define NIBBLE_SERIAL_ADDER_SUB_EN to add a subtract port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end

    state_t           r_state_q,     w_state_d;
    logic             r_in_ready_q,  w_in_ready_d;
    logic             r_out_valid_q, w_out_valid_d;
    logic [WIDTH-1:0] r_a_q,         w_a_d;
    logic [WIDTH-1:0] r_b_q,         w_b_d;
    logic [WIDTH-1:0] r_sum_q,       w_sum_d;
    logic             r_carry_q,     w_carry_d;
    logic [CNT_W-1:0] r_cnt_q,       w_cnt_d;
    logic             r_cout_q,      w_cout_d;
    logic             r_ovf_q,       w_ovf_d;
    logic             r_a_msb_q,     w_a_msb_d;
    logic             r_b_msb_q,     w_b_msb_d;

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;
    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;

    // Subtraction folds into the adder as a + ~b + 1, resolved at capture.
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = cin;
`endif

    cla_nibble u_cla_nibble (
        .a    (r_a_q[3:0]),
        .b    (r_b_q[3:0]),
        .cin  (r_carry_q),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_out_valid_d = r_out_valid_q;
        w_a_d         = r_a_q;
        w_b_d         = r_b_q;
        w_sum_d       = r_sum_q;
        w_carry_d     = r_carry_q;
        w_cnt_d       = r_cnt_q;
        w_cout_d      = r_cout_q;
        w_ovf_d       = r_ovf_q;
        w_a_msb_d     = r_a_msb_q;
        w_b_msb_d     = r_b_msb_q;

        case (r_state_q)
            IDLE: begin
                if (in_valid && r_in_ready_q) begin
                    w_a_d     = a;
                    w_b_d     = w_b_eff;
                    w_carry_d = w_cin_eff;
                    w_a_msb_d = a[WIDTH-1];
                    w_b_msb_d = w_b_eff[WIDTH-1];
                    w_cnt_d   = '0;
                    w_state_d = RUN;
                end
            end
            RUN: begin
                w_sum_d   = {w_slice_sum, r_sum_q[WIDTH-1:NIBBLE_W]};
                w_a_d     = {{NIBBLE_W{1'b0}}, r_a_q[WIDTH-1:NIBBLE_W]};
                w_b_d     = {{NIBBLE_W{1'b0}}, r_b_q[WIDTH-1:NIBBLE_W]};
                w_carry_d = w_slice_cout;
                w_cnt_d   = r_cnt_q + 1'b1;
                if (r_cnt_q == CNT_W'(NIB - 1)) begin
                    w_state_d     = DONE;
                    w_out_valid_d = 1'b1;
                    w_cout_d      = w_slice_cout;
                    w_ovf_d       = (r_a_msb_q == r_b_msb_q) && (w_slice_sum[3] != r_a_msb_q);
                end
            end
            DONE: begin
                if (r_out_valid_q && out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_state_d     = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase

        w_in_ready_d = (w_state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q     <= IDLE;
            r_in_ready_q  <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_sum_q       <= '0;
            r_carry_q     <= 1'b0;
            r_cnt_q       <= '0;
            r_cout_q      <= 1'b0;
            r_ovf_q       <= 1'b0;
            r_a_msb_q     <= 1'b0;
            r_b_msb_q     <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_sum_q       <= w_sum_d;
            r_carry_q     <= w_carry_d;
            r_cnt_q       <= w_cnt_d;
            r_cout_q      <= w_cout_d;
            r_ovf_q       <= w_ovf_d;
            r_a_msb_q     <= w_a_msb_d;
            r_b_msb_q     <= w_b_msb_d;
        end
    end

    assign in_ready  = r_in_ready_q;
    assign out_valid = r_out_valid_q;
    assign sum       = r_sum_q;
    assign cout      = r_cout_q;
    assign ovf       = r_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
//  Module   : tb_nibble_serial_adder
//  Brief    : Directed self-checking bench for nibble_serial_adder (WIDTH=16).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic         sub       = 1'b0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
    } res_t;

    res_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci, input logic sb_i);
        logic [W-1:0] yy;
        logic [W:0]   full;
        res_t         r;
        yy   = sb_i ? ~y : y;
        full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (sb_i ? 1'b1 : ci)};
        r.s  = full[W-1:0];
        r.c  = full[W];
        r.v  = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready_timeout"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic send(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic ci, input logic sb_i, input bit push);
        wait_ready(tag);
        a        = x;
        b        = y;
        cin      = ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub      = sb_i;
`endif
        in_valid = 1'b1;
        if (push) sb.push_back(model(x, y, ci, sb_i));
        @(negedge clk);
        in_valid = 1'b0;
        // Operands are free to change once accepted.
        a        = W'($urandom);
        b        = W'($urandom);
        cin      = ~ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub      = ~sb_i;
`endif
        check({tag, "_in_ready_low"}, {31'd0, in_ready}, 32'd0);
    endtask

    task automatic receive(input string tag, input int hold);
        int   n = 0;
        res_t e;
        while (out_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, NIB);
        check({tag, "_sb_nonempty"}, {31'd0, (sb.size() != 0)}, 32'd1);
        e = (sb.size() != 0) ? sb.pop_front() : '0;
        check({tag, "_sum"},  {16'd0, sum}, {16'd0, e.s});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, e.c});
        check({tag, "_ovf"},  {31'd0, ovf},  {31'd0, e.v});
        for (int i = 0; i < hold; i++) begin
            in_valid = ~in_valid;
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
            check({tag, "_hold_res"}, {14'd0, sum, cout, ovf}, {14'd0, e.s, e.c, e.v});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, "_drain_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [W-1:0] tab_a [4];
        logic [W-1:0] tab_b [4];
        int unsigned  prev_acc;
        int unsigned  acc;
        int           n;
        bit           seen;
        res_t         e;

        tab_a = '{16'h0F0F, 16'hFFFF, 16'h8000, 16'hABCD};
        tab_b = '{16'hF0F1, 16'hFFFF, 16'h8000, 16'h1111};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_sum",       {16'd0, sum},       32'd0);
        check("rst_cout_ovf",  {30'd0, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", {31'd0, in_ready}, 32'd1);

        // Plain adds: carry out, signed overflow, carry in
        send("t1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        receive("t1", 0);
        send("t2a", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        receive("t2a", 0);
        send("t2b", 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
        receive("t2b", 0);

        // Back-pressure in DONE with in_valid toggling
        send("t3", 16'h8001, 16'h8001, 1'b0, 1'b0, 1'b1);
        receive("t3", 5);

        // Reset during RUN abandons the add
        send("t4", 16'hAAAA, 16'h5555, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t4_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t4_rst_ready", {31'd0, in_ready},  32'd0);
        check("t4_rst_res",   {14'd0, sum, cout, ovf}, 32'd0);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("t4_no_result", {31'd0, seen}, 32'd0);
        send("t4b", 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);
        receive("t4b", 0);

        // Back-to-back with in_valid and out_ready held high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (in_ready !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("t5_ready_timeout", {31'd0, in_ready}, 32'd1);
            a   = tab_a[k];
            b   = tab_b[k];
            cin = k[0];
            sb.push_back(model(tab_a[k], tab_b[k], k[0], 1'b0));
            acc = cyc;
            if (k > 0) check("t5_spacing", acc - prev_acc, NIB + 2);
            prev_acc = acc;
            @(negedge clk);
            n = 0;
            while (out_valid !== 1'b1 && n < 50) begin
                @(negedge clk);
                n++;
            end
            check("t5_latency", n, NIB);
            e = (sb.size() != 0) ? sb.pop_front() : '0;
            check("t5_res", {14'd0, sum, cout, ovf}, {14'd0, e.s, e.c, e.v});
            if (k == 3) in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("t5_final_idle", {30'd0, in_ready, out_valid}, 32'd2);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        // Subtraction
        send("t6a", 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
        receive("t6a", 0);
        send("t6b", 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1);
        receive("t6b", 0);
        send("t6c", 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b1);
        receive("t6c", 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-word adder that feeds operands through a 4-bit carry-lookahead slice one nibble per clock, from the least-significant nibble upward.
The carry is registered between nibbles.
Operands arrive on a valid/ready input handshake, and the result leaves on a valid/ready output handshake.
This block is the sequencing stage wrapped around the team's 4-bit CLA datapath, used wherever WIDTH-bit adds are needed at low area.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8; other values are an elaboration error.
NIB, WIDTH/4 (derived localparam, not overridable), number of nibble steps per add.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset: one clock; reset is synchronous and active-low
in_valid  in  1  operands a, b, cin are valid
in_ready  out  1  block can accept operands
a  in  WIDTH  operand A
b  in  WIDTH  operand B
cin  in  1  carry-in to nibble 0
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  WIDTH  result
cout  out  1  carry out of MSB nibble
ovf  out  1  signed (two's complement) overflow

Behaviour:
- Reset (rst_n=0 at a rising edge, in any state):
  - state <= IDLE; in_ready <= 0; out_valid, sum, cout, ovf, nibble counter and carry register <= 0.
  - Reset mid-RUN or mid-DONE abandons the operation; no result is emitted.
- in_ready is registered: 1 in IDLE, 0 in RUN and DONE. It rises on the first edge after reset is released.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - When in_valid&&in_ready at an edge, capture a, b and cin into the A/B shift registers and the carry register.
  - Clear the counter to 0 and go to RUN.
  - in_valid without in_ready is ignored.
- RUN, each edge:
  - The slice adds A[3:0], B[3:0] and carry.
  - The 4-bit result is shifted into the top of the sum register, which shifts right by 4.
  - The slice carry-out goes to the carry register. A and B shift right by 4. The counter increments.
  - When counter==NIB-1, go to DONE. cout <= final carry.
  - ovf <= (a_msb==b_msb) && (sum_msb!=a_msb), using the MSBs of the captured operands and of the final sum.
- Latency: the acceptance edge is E0; out_valid is high after edge E_NIB (4 cycles for WIDTH=16).
- DONE:
  - out_valid=1; sum, cout and ovf are held stable while out_ready=0, for any number of cycles.
  - On out_valid&&out_ready, clear out_valid and go to IDLE; in_ready rises on the same edge.
- Throughput: one add per NIB+2 cycles minimum. There is no overlap of accept and drain.
- Arithmetic is modulo 2^WIDTH; the carry chain between nibbles matches a full WIDTH-bit ripple of lookahead slices.
- in_valid or out_ready toggling in states where they are not sampled has no effect.
- a, b and cin may change after acceptance without affecting the result.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port sub (in, 1), captured with the operands.
  - sub=1: the block computes a-b as a + ~b + 1. cin is ignored and forced to 1. cout=1 means no borrow. ovf is computed using ~b's MSB.
  - sub=0: identical to the undefined case.
- Undefined: no sub port; add only.

Decomposition:
- Package nibble_serial_adder_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - localparam NIBBLE_W=4;
  - a function checking the WIDTH legality.
- One sub-module is natural: cla_nibble, a combinational 4-bit carry-lookahead slice (a, b, cin -> sum[3:0], cout), instantiated once.

Test Plan:
1. WIDTH=16: a=0xFFFF, b=0x0001, cin=0 -> out_valid 4 cycles after accept; sum=0x0000, cout=1, ovf=0.
2. a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
3. Back-pressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout, ovf stable; in_ready=0 throughout; in_valid pulses are ignored. out_ready=1 -> IDLE next edge, in_ready=1.
4. Reset mid-RUN: accept a=0xAAAA, b=0x5555, then rst_n=0 at the 2nd RUN edge -> all outputs 0, no out_valid. The next add 0x0001+0x0002 yields 0x0003.
5. Back-to-back: in_valid held high with out_ready=1 -> accepts spaced exactly NIB+2 cycles apart; results are in order.
6. SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
